// File: rtl/rectangle_pkg.sv
// rtl/rectangle_pkg.sv - shared constants, S-boxes and FSM type for the RECTANGLE decrypt core
package rectangle_pkg;

    localparam int NROUNDS = 25;
    localparam int ROW_W   = 16;
    localparam int BLOCK_W = 64;

    // Encrypt-direction left-rotation per row; decryption rotates right by the same amounts.
    localparam int ROT [4] = '{0, 1, 12, 13};

    localparam logic [3:0] SBOX [16] = '{
        4'h6, 4'h5, 4'hC, 4'hA, 4'h1, 4'hE, 4'h7, 4'h9,
        4'hB, 4'h0, 4'h3, 4'hD, 4'h8, 4'hF, 4'h4, 4'h2
    };

    localparam logic [3:0] INV_SBOX [16] = '{
        4'h9, 4'h4, 4'hF, 4'hA, 4'hE, 4'h1, 4'h0, 4'h6,
        4'hC, 4'h7, 4'h3, 4'h8, 4'h2, 4'hB, 4'h5, 4'hD
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_DONE
    } fsm_t;

    function automatic logic [ROW_W-1:0] rotr_row(input logic [ROW_W-1:0] x, input int n);
        return (x >> n) | (x << (ROW_W - n));
    endfunction

endpackage

// File: rtl/rectangle_inv_round.sv
// rtl/rectangle_inv_round.sv - combinational inverse round: InvShiftRow, InvSubColumn, AddRoundKey
module rectangle_inv_round
    import rectangle_pkg::*;
(
    input  logic [BLOCK_W-1:0] state_i,
    input  logic [BLOCK_W-1:0] rk_i,
    output logic [BLOCK_W-1:0] state_o
);

    logic [BLOCK_W-1:0] shifted;
    logic [BLOCK_W-1:0] subbed;
    logic [3:0]         nib;

    always_comb begin
        shifted = '0;
        for (int r = 0; r < 4; r++) begin
            shifted[r*ROW_W +: ROW_W] = rotr_row(state_i[r*ROW_W +: ROW_W], ROT[r]);
        end
    end

    // Each column is one S-box lane: bit j of rows 3..0 forms the nibble.
    always_comb begin
        subbed = '0;
        nib    = '0;
        for (int j = 0; j < ROW_W; j++) begin
            nib = INV_SBOX[{shifted[3*ROW_W+j], shifted[2*ROW_W+j],
                            shifted[ROW_W+j],   shifted[j]}];
            subbed[j]         = nib[0];
            subbed[ROW_W+j]   = nib[1];
            subbed[2*ROW_W+j] = nib[2];
            subbed[3*ROW_W+j] = nib[3];
        end
    end

    assign state_o = subbed ^ rk_i;

endmodule

// File: rtl/rectangle_decrypt_core.sv
// rtl/rectangle_decrypt_core.sv - iterative RECTANGLE decryption, one round per clock; RECT_DEC_DBG_STATE_EN adds dbg_state/dbg_round ports
module rectangle_decrypt_core #(
    parameter int NROUNDS = rectangle_pkg::NROUNDS,
    parameter int IDX_W   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_data,
    output logic [IDX_W-1:0] rk_idx,
    input  logic [63:0]      rk,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data
`ifdef RECT_DEC_DBG_STATE_EN
    ,
    output logic [63:0]      dbg_state,
    output logic [IDX_W-1:0] dbg_round
`endif
);

    import rectangle_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NROUNDS);

    fsm_t               fsm_q, fsm_d;
    logic [IDX_W-1:0]   ctr_q, ctr_d;
    logic [BLOCK_W-1:0] state_q, state_d;
    logic [BLOCK_W-1:0] out_q, out_d;
    logic [BLOCK_W-1:0] round_out;

    rectangle_inv_round u_inv_round (
        .state_i (state_q),
        .rk_i    (rk),
        .state_o (round_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= ST_IDLE;
            ctr_q   <= '0;
            state_q <= '0;
            out_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            ctr_q   <= ctr_d;
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    // rk_idx decodes only from registered state so the key store sees a stable index.
    always_comb begin
        fsm_d     = fsm_q;
        ctr_d     = ctr_q;
        state_d   = state_q;
        out_d     = out_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        rk_idx    = LAST_IDX;
        case (fsm_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = in_data ^ rk;
                    ctr_d   = LAST_IDX - IDX_W'(1);
                    fsm_d   = ST_ROUND;
                end
            end
            ST_ROUND: begin
                rk_idx  = ctr_q;
                state_d = round_out;
                if (ctr_q == '0) begin
                    out_d = round_out;
                    fsm_d = ST_DONE;
                end else begin
                    ctr_d = ctr_q - IDX_W'(1);
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    fsm_d = ST_IDLE;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    assign out_data = out_q;

`ifdef RECT_DEC_DBG_STATE_EN
    assign dbg_state = state_q;
    assign dbg_round = ctr_q;
`endif

endmodule

// File: tb/tb_rectangle_decrypt_core.sv
// tb/tb_rectangle_decrypt_core.sv - scoreboard bench: golden encrypt + key schedule, round trip through the decrypt core
module tb_rectangle_decrypt_core;

    localparam int NR = 25;
    localparam logic [3:0] SBOX [16] = '{
        4'h6, 4'h5, 4'hC, 4'hA, 4'h1, 4'hE, 4'h7, 4'h9,
        4'hB, 4'h0, 4'h3, 4'hD, 4'h8, 4'hF, 4'h4, 4'h2
    };

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic [4:0]  rk_idx;
    logic [63:0] rk;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
`ifdef RECT_DEC_DBG_STATE_EN
    logic [63:0] dbg_state;
    logic [4:0]  dbg_round;
`endif

    logic [63:0] rk_tab [0:NR];
    logic [63:0] exp_q [$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_out = 0;
    int          rdy_mode = 0;

    always #5 clk = ~clk;

    rectangle_decrypt_core #(.NROUNDS(NR), .IDX_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .rk_idx    (rk_idx),
        .rk        (rk),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef RECT_DEC_DBG_STATE_EN
        ,
        .dbg_state (dbg_state),
        .dbg_round (dbg_round)
`endif
    );

    // External round-key store, combinational lookup.
    always_comb rk = (rk_idx <= 5'(NR)) ? rk_tab[rk_idx] : 64'h0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] rotl16(input logic [15:0] x, input int n);
        logic [31:0] d;
        d = {x, x};
        return 16'(d >> (16 - n));
    endfunction

    function automatic logic [63:0] sub_col(input logic [63:0] s);
        logic [63:0] o;
        logic [3:0]  v;
        o = '0;
        for (int j = 0; j < 16; j++) begin
            v = SBOX[{s[48+j], s[32+j], s[16+j], s[j]}];
            o[j] = v[0]; o[16+j] = v[1]; o[32+j] = v[2]; o[48+j] = v[3];
        end
        return o;
    endfunction

    function automatic logic [63:0] shift_row(input logic [63:0] s);
        return {rotl16(s[63:48], 13), rotl16(s[47:32], 12), rotl16(s[31:16], 1), s[15:0]};
    endfunction

    function automatic logic [63:0] encrypt(input logic [63:0] pt);
        logic [63:0] s;
        s = pt;
        for (int i = 0; i < NR; i++) s = shift_row(sub_col(s ^ rk_tab[i]));
        return s ^ rk_tab[NR];
    endfunction

    task automatic load_keys(input logic [79:0] key);
        logic [15:0] r [5];
        logic [15:0] t;
        logic [4:0]  rc;
        logic [3:0]  v;
        rc = 5'h01;
        for (int i = 0; i < 5; i++) r[i] = key[16*i +: 16];
        for (int i = 0; i <= NR; i++) begin
            rk_tab[i] = {r[3], r[2], r[1], r[0]};
            for (int j = 0; j < 4; j++) begin
                v = SBOX[{r[3][j], r[2][j], r[1][j], r[0][j]}];
                r[0][j] = v[0]; r[1][j] = v[1]; r[2][j] = v[2]; r[3][j] = v[3];
            end
            t    = r[0];
            r[0] = rotl16(r[0], 8) ^ r[1];
            r[1] = r[2];
            r[2] = r[3];
            r[3] = rotl16(r[3], 12) ^ r[4];
            r[4] = t;
            r[0][4:0] = r[0][4:0] ^ rc;
            rc = {rc[3:0], rc[4] ^ rc[2]};
        end
    endtask

    // Returns at the falling edge just after the accepting edge.
    task automatic send(input logic [63:0] pt, input logic [79:0] key);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            check_eq("in_ready_timeout", 64'(in_ready), 64'd1);
            return;
        end
        load_keys(key);
        exp_q.push_back(pt);
        in_data  = encrypt(pt);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_timed(input logic [63:0] pt, input logic [79:0] key, input bit chk_idx);
        send(pt, key);
        for (int k = 0; k < NR; k++) begin
            if (chk_idx) check_eq($sformatf("rk_idx_r%0d", k), 64'(rk_idx), 64'(NR - 1 - k));
            if (k == NR - 1) check_eq("out_valid_early", 64'(out_valid), 64'd0);
            @(negedge clk);
        end
        check_eq("latency_out_valid", 64'(out_valid), 64'd1);
        if (chk_idx) check_eq("rk_idx_done", 64'(rk_idx), 64'(NR));
    endtask

    // Owns out_ready; a handshake is scored at the falling edge before the edge that completes it.
    initial begin
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
            if (rst_n && out_valid && out_ready) begin
                n_out++;
                check_eq("q_nonempty", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) check_eq("out_data", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] pt;
        logic [79:0] key;
        int          w;
        int          n0;

        for (int i = 0; i <= NR; i++) rk_tab[i] = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_data", out_data, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle_in_ready", 64'(in_ready), 64'd1);
        check_eq("idle_rk_idx", 64'(rk_idx), 64'(NR));

`ifdef RECT_DEC_DBG_STATE_EN
        in_data  = '0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("dbg_load", dbg_state, 64'h0);
        check_eq("dbg_round_load", 64'(dbg_round), 64'(NR - 1));
        @(negedge clk);
        check_eq("dbg_round1", dbg_state, 64'hFFFF_0000_0000_FFFF);
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
`endif

        run_timed(64'h0, 80'h0, 1'b1);
        run_timed(64'hFFFF_FFFF_FFFF_FFFF, 80'h0, 1'b0);
        run_timed(64'h0123_4567_89AB_CDEF, 80'h0, 1'b0);

        // Back-pressure
        @(posedge clk);
        #1 rdy_mode = 2;
        pt = 64'h5A5A_1234_C3C3_9876;
        send(pt, 80'h0);
        w = 0;
        while (!out_valid && w < 40) begin
            @(negedge clk);
            w++;
        end
        check_eq("bp_valid", 64'(out_valid), 64'd1);
        for (int c = 0; c < 10; c++) begin
            check_eq("bp_data_stable", out_data, pt);
            check_eq("bp_in_ready", 64'(in_ready), 64'd0);
            check_eq("bp_out_valid", 64'(out_valid), 64'd1);
            in_valid = 1'b1;
            in_data  = {$urandom, $urandom};
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rdy_mode = 0;
        @(negedge clk);
        @(negedge clk);
        check_eq("bp_release_valid", 64'(out_valid), 64'd0);
        check_eq("bp_release_ready", 64'(in_ready), 64'd1);
        check_eq("bp_queue_empty", 64'(exp_q.size()), 64'd0);

        // Reset mid-operation
        key = 80'h1234_5678_9ABC_DEF0_1357;
        send(64'hDEAD_BEEF_0BAD_F00D, key);
        repeat (12) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("abort_out_valid", 64'(out_valid), 64'd0);
        check_eq("abort_out_data", out_data, 64'h0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run_timed(64'hCAFE_F00D_1122_3344, key, 1'b0);

        // Back-to-back random traffic
        @(posedge clk);
        #1 rdy_mode = 1;
        n0 = n_out;
        for (int b = 0; b < 100; b++) begin
            key = 80'({$urandom, $urandom, $urandom});
            pt  = {$urandom, $urandom};
            send(pt, key);
        end
        w = 0;
        while (exp_q.size() != 0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        check_eq("b2b_drained", 64'(exp_q.size()), 64'd0);
        check_eq("b2b_count", 64'(n_out - n0), 64'd100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rectangle_decrypt_core.md
Name: rectangle_decrypt_core

Overview:
- Iterative RECTANGLE block-cipher decryption datapath, one round per clock.
- Consumes 64-bit ciphertext; produces 64-bit plaintext after 25 inverse rounds.
- Implements inverse ShiftRow (row rotations right by 0/1/12/13), inverse SubColumn and AddRoundKey.
- Round keys come from an external round-key store, indexed by this block; the key schedule lives elsewhere.

Parameters:
- NROUNDS, 25, number of cipher rounds; round keys 0..NROUNDS are used.
- IDX_W, 5, width of rk_idx; must satisfy 2^IDX_W > NROUNDS.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, ciphertext present.
- in_ready, output, 1, core can accept ciphertext.
- in_data, input, 64, ciphertext; row r = bits [16r+15:16r].
- rk_idx, output, IDX_W, index of the round key required this cycle.
- rk, input, 64, round key for rk_idx; combinational, valid in the same cycle.
- out_valid, output, 1, plaintext present.
- out_ready, input, 1, downstream accepts plaintext.
- out_data, output, 64, plaintext.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE; state reg, round counter and out_data are all zero.
  - out_valid=0; in_ready=1 once rst_n deasserts.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1; rk_idx=NROUNDS.
  - On in_valid=1: state <= in_data ^ rk (final whitening key), ctr <= NROUNDS-1, go to ROUND.
- ROUND:
  - in_ready=0; rk_idx=ctr.
  - Each cycle: state <= InvSubColumn(InvShiftRow(state)) ^ rk.
  - If ctr==0: go to DONE and register out_data <= the new state. Otherwise ctr <= ctr-1.
- InvShiftRow:
  - row0 unchanged.
  - row1 = {row1[0], row1[15:1]} (rotate right 1).
  - row2 rotated right 12.
  - row3 rotated right 13.
- InvSubColumn:
  - For column j in 0..15, nibble = {row3[j],row2[j],row1[j],row0[j]}.
  - Inverse S-box, indexed 0..F: 9,4,F,A,E,1,0,6,C,7,3,8,2,B,5,D.
  - The result bits are written back to the same positions.
- DONE:
  - out_valid=1; out_data held stable; in_ready=0; rk_idx=NROUNDS.
  - On out_ready=1: out_valid drops next cycle, go to IDLE.
- Latency: accept at edge 0, out_valid high after edge NROUNDS (25 cycles). Throughput is one block per 27 cycles at full out_ready.
- in_valid is ignored outside IDLE. in_data is sampled only on the accepting edge.
- Back-pressure: out_valid and out_data stay stable indefinitely while out_ready=0.
- Reset mid-operation: everything aborts immediately, with no partial output.
- rk_idx is a pure function of FSM state and ctr (glitch-free decode, no dependence on inputs).

Optional Feature:
- Macro: RECT_DEC_DBG_STATE_EN.
- Defined: adds output ports dbg_state[63:0] (live state register) and dbg_round[IDX_W-1:0] (current ctr), used for round-by-round checking.
- Undefined: these ports and their logic are absent. Functional behaviour is identical either way.

Decomposition:
- Shared package rectangle_pkg holds:
  - NROUNDS, ROW_W=16, BLOCK_W=64.
  - Row rotation amounts {0,1,12,13}.
  - Forward and inverse S-box constant arrays.
  - FSM state typedef.
- One natural sub-module: rectangle_inv_round. It is combinational (state, rk) -> next state (InvShiftRow, InvSubColumn, AddRoundKey) and is instantiated once.

Test Plan:
- Single-round check (DBG on): all round keys 0, ct=0.
  - After load: dbg_state=0.
  - After first ROUND edge: dbg_state=0xFFFF_0000_0000_FFFF.
- Round trip: fixed plaintexts 0, 0xFFFF_FFFF_FFFF_FFFF and 0x0123_4567_89AB_CDEF, with round keys from a golden 80-bit key schedule for key 0.
  - Encrypt each in the golden model and feed the ciphertext.
  - Required: out_data equals the plaintext, with out_valid exactly 25 cycles after acceptance.
- rk_idx sequence: record rk_idx per cycle; required 25 (IDLE), 24, 23, …, 0, then 25 in DONE.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid.
  - out_data stays stable, in_ready stays 0.
  - New in_valid pulses are ignored.
  - Release: out_valid falls next cycle, in_ready rises.
- Reset mid-operation: assert rst_n=0 at round 12.
  - Outputs clear asynchronously (out_valid=0, out_data=0).
  - After release, a fresh block decrypts correctly.
- Back-to-back: 100 random blocks with random keys and random out_ready.
  - All outputs match the golden model, in order, with none dropped or duplicated.
